// File: rtl/zx_vram_arbiter.sv
// Screen RAM arbiter: ULA fetches win every ce_7mn slot. CPU writes are posted
// through a small FIFO. CPU reads wait until all posted writes have drained.
module zx_vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce_7mn,
  input  logic                          ula_req,
  input  logic [ADDR_W-1:0]             ula_addr,
  output logic [7:0]                    ula_dout,
  output logic                          ula_valid,
  input  logic                          cpu_wr,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  output logic                          cpu_wr_ready,
  input  logic                          cpu_rd_req,
  input  logic [ADDR_W-1:0]             cpu_rd_addr,
  output logic                          cpu_rd_ack,
  output logic [7:0]                    cpu_rd_data,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [7:0]                    mem_din,
  input  logic [7:0]                    mem_dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_ULA_RD = 2'd1,
    GNT_CPU_WR = 2'd2,
    GNT_CPU_RD = 2'd3
  } grant_t;

  grant_t              grant_reg, grant_next;
  grant_t              cap_reg;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [7:0]          fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic                overflow_reg;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic                mem_we_reg;
  logic [7:0]          mem_din_reg;
  logic [7:0]          ula_dout_reg, cpu_rd_data_reg;
  logic                ula_valid_reg, cpu_rd_ack_reg;

  logic fifo_empty, fifo_full, rd_busy, push, pop;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
  // A read still in its two-cycle pipeline must not be granted again.
  assign rd_busy    = (grant_reg == GNT_CPU_RD) || (cap_reg == GNT_CPU_RD);
  assign push       = cpu_wr && !fifo_full;
  assign pop        = (grant_next == GNT_CPU_WR);

  always_comb begin
    grant_next    = GNT_NONE;
    mem_addr_next = mem_addr_reg;
    if (ce_7mn) begin
      if (ula_req)
        grant_next = GNT_ULA_RD;
      else if (!fifo_empty)
        grant_next = GNT_CPU_WR;
      else if (cpu_rd_req && !rd_busy)
        grant_next = GNT_CPU_RD;
    end
    case (grant_next)
      GNT_ULA_RD: mem_addr_next = ula_addr;
      GNT_CPU_WR: mem_addr_next = fifo_addr[rd_ptr_reg];
      GNT_CPU_RD: mem_addr_next = cpu_rd_addr;
      default:    mem_addr_next = mem_addr_reg;
    endcase
  end

  // One storage slot per entry; only the slot under the write pointer loads.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk_sys) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_addr[gi] <= cpu_wr_addr;
          fifo_data[gi] <= cpu_wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant_reg       <= GNT_NONE;
      cap_reg         <= GNT_NONE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      overflow_reg    <= 1'b0;
      mem_addr_reg    <= '0;
      mem_we_reg      <= 1'b0;
      mem_din_reg     <= '0;
      ula_dout_reg    <= '0;
      ula_valid_reg   <= 1'b0;
      cpu_rd_data_reg <= '0;
      cpu_rd_ack_reg  <= 1'b0;
    end else begin
      grant_reg    <= grant_next;
      // A fresh slot decision cancels any capture still pending.
      cap_reg      <= ce_7mn ? GNT_NONE : grant_reg;
      mem_addr_reg <= mem_addr_next;
      mem_we_reg   <= pop;
      if (pop)
        mem_din_reg <= fifo_data[rd_ptr_reg];

      ula_valid_reg  <= (cap_reg == GNT_ULA_RD);
      cpu_rd_ack_reg <= (cap_reg == GNT_CPU_RD);
      if (cap_reg == GNT_ULA_RD)
        ula_dout_reg <= mem_dout;
      if (cap_reg == GNT_CPU_RD)
        cpu_rd_data_reg <= mem_dout;

      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
      if (cpu_wr && fifo_full)
        overflow_reg <= 1'b1;
    end
  end

  assign cpu_wr_ready = !fifo_full;
  assign fifo_level   = level_reg;
  assign overflow     = overflow_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_we       = mem_we_reg;
  assign mem_din      = mem_din_reg;
  assign ula_dout     = ula_dout_reg;
  assign ula_valid    = ula_valid_reg;
  assign cpu_rd_data  = cpu_rd_data_reg;
  assign cpu_rd_ack   = cpu_rd_ack_reg;

endmodule

// File: doc/zx_vram_arbiter.md
Name: zx_vram_arbiter

Overview:
- Shares one single-port synchronous screen RAM between the ULA video fetcher and the CPU.
- The ULA has absolute priority on every ce_7mn slot.
- CPU writes are posted into a small FIFO and drained in slots the ULA does not use.
- CPU reads use a req/ack handshake and are ordered behind all posted writes.
- Sits between the ULA's vram_addr/vram_dout pair, the CPU memory decoder and the dual-bank screen RAM.

Parameters:
FIFO_DEPTH, 4, posted-write FIFO entries; power of two, 2..16
ADDR_W, 15, screen RAM address width

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
ce_7mn  in  1  slot strobe; one clk_sys wide; ce_7mn pulses are at least 3 clk_sys apart
ula_req  in  1  ULA wants a fetch this slot
ula_addr  in  ADDR_W  ULA fetch address
ula_dout  out  8  last ULA fetch data
ula_valid  out  1  one-cycle pulse when ula_dout updates
cpu_wr  in  1  one-cycle write strobe
cpu_wr_addr  in  ADDR_W  write address
cpu_wr_data  in  8  write data
cpu_wr_ready  out  1  FIFO not full
cpu_rd_req  in  1  level read request; held until ack
cpu_rd_addr  in  ADDR_W  read address; stable while req
cpu_rd_ack  out  1  one-cycle pulse, data valid
cpu_rd_data  out  8  read data; held until next ack
overflow  out  1  sticky: a write was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_din  out  8  RAM write data
mem_dout  in  8  RAM read data, 1 clk_sys latency

Behaviour:
- Reset values: all outputs 0 except cpu_wr_ready=1; FIFO empty; grant=NONE; pending read cleared.
- Slot decision happens on the clk_sys edge where ce_7mn=1. Grant priority:
  1. ULA when ula_req=1.
  2. Otherwise FIFO head, if FIFO non-empty.
  3. Otherwise the CPU read, if cpu_rd_req=1, FIFO empty and no ack is outstanding.
  4. Otherwise NONE.
- Grant register states: NONE, ULA_RD, CPU_WR, CPU_RD. It returns to NONE one cycle after capture.
- Slot cycle timing:
  - Cycle T = the ce_7mn edge. mem_addr, mem_we and mem_din are registered and presented in T+1.
  - mem_dout is valid in T+2 and is captured on that edge.
  - mem_we is high for exactly one clk_sys (T+1), and only for CPU_WR.
- ULA_RD: ula_dout <= mem_dout and ula_valid=1 at T+2. ula_dout holds otherwise. Total latency is 2 clk_sys.
- CPU_WR: pop the FIFO head at T+1. mem_din = head data.
- CPU_RD: cpu_rd_data <= mem_dout and cpu_rd_ack=1 at T+2. A request still high on the next slot is treated as a new read.
- Ordering: reads never bypass posted writes. A read waits until the FIFO is empty, which gives read-after-write coherency.
- FIFO push: cpu_wr=1 and not full.
  - cpu_wr while full: write dropped, overflow <= 1 (sticky until reset), level unchanged.
  - Push and pop on the same edge: level unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- cpu_wr_ready = (level != FIFO_DEPTH), combinational from level.
- ULA starvation of the CPU is allowed (no fairness). The FIFO drains only in idle ULA slots.
- Between slots mem_we=0 and mem_addr holds its last value.
- Reset mid-slot: an in-flight write is abandoned (mem_we forced 0 next cycle). No ack or ula_valid is generated and FIFO contents are lost.
- ce_7mn while grant != NONE cannot occur given the pulse spacing. If it does, the new slot decision overrides and the old capture is cancelled.

Test Plan:
- ULA priority: ula_req=1, ula_addr=0x1800, RAM[0x1800]=0xA5, FIFO holding 1 write. Expect the ULA slot to win, ula_dout=0xA5 with ula_valid at T+2, and no mem_we in that slot.
- Posted-write drain: 3 cpu_wr to 0x0000..0x0002 (data 0x11,0x22,0x33), ula_req=0. Expect 3 consecutive slots with mem_we, in order; fifo_level goes 3→0.
- Full/overflow (DEPTH=4): ula_req held 1, 5 cpu_wr strobes. Expect level=4, cpu_wr_ready=0 after the 4th strobe, overflow=1 after the 5th; a release then drains exactly 4 entries.
- RAW ordering: cpu_wr 0x4000←0x5A immediately followed by cpu_rd_req at 0x4000. Expect the write slot first, then the read slot; cpu_rd_data=0x5A with one ack pulse.
- Simultaneous push/pop: level=2, cpu_wr on the same edge as a drain pop. Expect level to stay 2 and later drain order to match push order.
- Reset mid-write: assert reset at T+1 of a CPU_WR slot. Expect mem_we=0 the next cycle, level=0, cpu_wr_ready=1, overflow=0, and no ack.
